cfg_chain_shadowed: RTL and testbench

- Parametrised multi-lane configuration shift chain for fabric config loading; successor to the single-bit shift chain.
- Shifts LANES bits per handshake beat into a shadow store of LANES x DEPTH bits.
- Commits the shadow store atomically to the active config_data outputs, so the fabric never sees partial config.
- Supports non-destructive circular readback of the shadow store through a valid/ready port.

---
 rtl/cfg_chain_pkg.sv | 19 +
 rtl/cfg_chain_shadowed_if.sv | 30 +++
 rtl/cfg_lane_chain.sv | 42 ++++
 rtl/cfg_chain_shadowed.sv | 127 ++++++++++++
 tb/tb_cfg_chain_shadowed.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_chain_pkg.sv
// Shared definitions for the shadowed multi-lane configuration chain:
// state encoding and the FSM state type.
package cfg_chain_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ENC_IDLE   = 2'b00;
    localparam logic [STATE_W-1:0] ENC_LOAD   = 2'b01;
    localparam logic [STATE_W-1:0] ENC_COMMIT = 2'b10;
    localparam logic [STATE_W-1:0] ENC_READ   = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = ENC_IDLE,
        ST_LOAD   = ENC_LOAD,
        ST_COMMIT = ENC_COMMIT,
        ST_READ   = ENC_READ
    } state_t;

endpackage

// File: rtl/cfg_chain_shadowed_if.sv
// Beat-level interface of the configuration chain: an input stream that
// feeds the shadow store and an output stream that reads it back.
//
// Handshake rule for both streams: a beat transfers on a rising clock edge
// where valid and ready are both high. The producer holds data stable while
// valid is high and not yet accepted. On this block, in_ready and out_valid
// are decoded from registered state only, so neither depends
// combinationally on in_valid or out_ready.
interface cfg_chain_shadowed_if #(
    parameter int LANES = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [LANES-1:0] out_data;

    // The side that feeds beats in and consumes readback beats.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The configuration chain itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/cfg_lane_chain.sv
// One lane of the shadow store: a DEPTH-long register that holds, shifts in
// a new bit at the top, or rotates position 0 back to the top.
module cfg_lane_chain #(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             rot_en,
    input  logic             shift_in,
    output logic [DEPTH-1:0] q
);

    logic [DEPTH-1:0] q_q;
    logic [DEPTH-1:0] q_d;
    logic             top_bit;

    // Next lane value: both shift and rotate move everything down one
    // position; they differ only in what enters at DEPTH-1.
    always_comb begin
        q_d     = q_q;
        top_bit = rot_en ? q_q[0] : shift_in;
        if (shift_en || rot_en) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                q_d[i] = q_q[i + 1];
            end
            q_d[DEPTH-1] = top_bit;
        end
    end

    // Lane register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/cfg_chain_shadowed.sv
// Multi-lane shadowed configuration chain. Beats are shifted into a shadow
// store, which is copied to config_data in one cycle so the fabric never
// sees a partial configuration. The shadow can be read back circularly
// without being disturbed.
module cfg_chain_shadowed
    import cfg_chain_pkg::*;
#(
    parameter  int LANES = 4,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    cfg_chain_shadowed_if.slave      bus,
    input  logic                     load_start,
    input  logic                     load_abort,
    input  logic                     rb_start,
    output logic                     busy,
    output logic                     done,
    output logic [CW-1:0]            beat_cnt,
    output logic [LANES*DEPTH-1:0]   config_data,
    output state_t                   dbg_state
);

    state_t                  state_q, state_d;
    logic [CW-1:0]           beat_cnt_q, beat_cnt_d;
    logic [LANES*DEPTH-1:0]  config_q, config_d;
    logic                    done_q, done_d;
    logic                    shift_en;
    logic                    rot_en;
    logic [LANES*DEPTH-1:0]  shadow_flat;
    logic [LANES-1:0]        lane_pos0;

    // One chain per lane; all lanes move in lockstep.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DEPTH-1:0] lane_bits;

        cfg_lane_chain #(
            .DEPTH (DEPTH)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .shift_en (shift_en),
            .rot_en   (rot_en),
            .shift_in (bus.in_data[l]),
            .q        (lane_bits)
        );

        assign shadow_flat[l*DEPTH +: DEPTH] = lane_bits;
        assign lane_pos0[l]                  = lane_bits[0];
    end

    // Session control: next state, beat counter, commit and done pulse.
    // An abort wins over a same-cycle beat, so the beat is dropped.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        config_d   = config_q;
        done_d     = 1'b0;
        shift_en   = 1'b0;
        rot_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d    = ST_LOAD;
                    beat_cnt_d = '0;
                end else if (rb_start) begin
                    state_d    = ST_READ;
                    beat_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (load_abort) begin
                    state_d = ST_IDLE;
                end else if (bus.in_valid) begin
                    shift_en   = 1'b1;
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (beat_cnt_q == CW'(DEPTH - 1)) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                config_d = shadow_flat;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_READ: begin
                if (bus.out_ready) begin
                    rot_en     = 1'b1;
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (beat_cnt_q == CW'(DEPTH - 1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            config_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            config_q   <= config_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.out_valid = (state_q == ST_READ);
    assign bus.out_data  = lane_pos0;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign beat_cnt      = beat_cnt_q;
    assign config_data   = config_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_cfg_chain_shadowed.sv
// Bench for cfg_chain_shadowed: a queue-based reference model checked every
// cycle, a shadow scoreboard for readback, directed literal checks, and a
// DEPTH=1/LANES=1 build.
module tb_cfg_chain_shadowed;
    import cfg_chain_pkg::*;

    localparam int L  = 4;
    localparam int D  = 16;
    localparam int CW = $clog2(D + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- main DUT ----------------
    logic             load_start, load_abort, rb_start;
    logic             busy, done;
    logic [CW-1:0]    beat_cnt;
    logic [L*D-1:0]   config_data;
    state_t           dbg_state;

    cfg_chain_shadowed_if #(.LANES(L)) bus ();

    cfg_chain_shadowed #(.LANES(L), .DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .load_start  (load_start),
        .load_abort  (load_abort),
        .rb_start    (rb_start),
        .busy        (busy),
        .done        (done),
        .beat_cnt    (beat_cnt),
        .config_data (config_data),
        .dbg_state   (dbg_state)
    );

    // ---------------- DEPTH=1, LANES=1 DUT ----------------
    logic       s_load_start, s_load_abort, s_rb_start;
    logic       s_busy, s_done;
    logic [0:0] s_beat_cnt;
    logic [0:0] s_config;
    state_t     s_dbg_state;

    cfg_chain_shadowed_if #(.LANES(1)) bus1 ();

    cfg_chain_shadowed #(.LANES(1), .DEPTH(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus1),
        .load_start  (s_load_start),
        .load_abort  (s_load_abort),
        .rb_start    (s_rb_start),
        .busy        (s_busy),
        .done        (s_done),
        .beat_cnt    (s_beat_cnt),
        .config_data (s_config),
        .dbg_state   (s_dbg_state)
    );

    // ---------------- counters and check ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Shadow held as a queue of beat words, index = position.
    // Loading drops the word at position 0 and appends at the top;
    // readback moves the position-0 word to the top.
    int             m_mode;   // 0 idle, 1 loading, 2 committing, 3 reading
    logic [L-1:0]   m_sh[$];
    logic [L*D-1:0] m_cfg;
    int             m_cnt;
    bit             m_done;

    always @(posedge clk) begin
        logic [L-1:0] w;
        if (!rst) begin
            m_mode = 0;
            m_sh.delete();
            for (int i = 0; i < D; i++) m_sh.push_back({L{1'b0}});
            m_cfg  = '0;
            m_cnt  = 0;
            m_done = 0;
        end else begin
            m_done = 0;
            case (m_mode)
                0: begin
                    if (load_start) begin m_mode = 1; m_cnt = 0; end
                    else if (rb_start) begin m_mode = 3; m_cnt = 0; end
                end
                1: begin
                    if (load_abort) m_mode = 0;
                    else if (bus.in_valid) begin
                        w = m_sh.pop_front();
                        m_sh.push_back(bus.in_data);
                        m_cnt++;
                        if (m_cnt == D) m_mode = 2;
                    end
                end
                2: begin
                    for (int l = 0; l < L; l++)
                        for (int i = 0; i < D; i++)
                            m_cfg[l*D+i] = m_sh[i][l];
                    m_done = 1;
                    m_mode = 0;
                end
                default: begin
                    if (bus.out_ready) begin
                        w = m_sh.pop_front();
                        m_sh.push_back(w);
                        m_cnt++;
                        if (m_cnt == D) m_mode = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",        busy,          m_mode != 0);
            check("in_ready",    bus.in_ready,  m_mode == 1);
            check("out_valid",   bus.out_valid, m_mode == 3);
            check("done",        done,          m_done);
            check("beat_cnt",    beat_cnt,      m_cnt);
            check("config_data", config_data,   m_cfg);
            if (m_mode == 3) check("out_data", bus.out_data, m_sh[0]);
        end
    end

    // ---------------- scoreboard ----------------
    logic [L-1:0] exp_q[$];   // expected shadow contents, index = position
    logic [L-1:0] got_q[$];   // words observed during the last readback

    task automatic exp_reset();
        exp_q.delete();
        for (int i = 0; i < D; i++) exp_q.push_back({L{1'b0}});
    endtask

    task automatic compare_rb(input string name);
        check({name, "_len"}, got_q.size(), D);
        for (int i = 0; i < D && i < got_q.size(); i++)
            check(name, got_q[i], exp_q[i]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // pattern: 0 index held, 1 index with valid every other cycle,
    //          2 constant all-ones held, 3 random valid and data
    task automatic feed(input int n, input int pattern);
        int got = 0;
        int guard = 0;
        logic v;
        logic [L-1:0] d;
        logic [L-1:0] drop;
        while (got < n && guard < 400) begin
            case (pattern)
                0: begin v = 1'b1; d = L'(got); end
                1: begin v = (guard % 2) == 0; d = L'(got); end
                2: begin v = 1'b1; d = {L{1'b1}}; end
                default: begin
                    v = $urandom_range(0, 2) != 0;
                    d = L'($urandom_range(0, (1 << L) - 1));
                    rb_start = $urandom_range(0, 3) == 0;
                end
            endcase
            bus.in_valid = v;
            bus.in_data  = d;
            if (v && bus.in_ready) begin
                got++;
                drop = exp_q.pop_front();
                exp_q.push_back(d);
            end
            step();
            guard++;
        end
        bus.in_valid = 1'b0;
        rb_start     = 1'b0;
        check("feed_beats", got, n);
    endtask

    task automatic readback();
        int got = 0;
        int guard = 0;
        logic r;
        rb_start = 1'b1;
        step();
        rb_start = 1'b0;
        got_q.delete();
        while (got < D && guard < 400) begin
            r = $urandom_range(0, 1);
            bus.out_ready = r;
            load_start    = $urandom_range(0, 3) == 0;
            if (r && bus.out_valid) begin
                got_q.push_back(bus.out_data);
                got++;
            end
            step();
            guard++;
        end
        bus.out_ready = 1'b0;
        load_start    = 1'b0;
        check("rb_beats", got, D);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [L*D-1:0] idx_cfg;
        idx_cfg = 64'hFF00_F0F0_CCCC_AAAA;

        rst = 1'b0;
        load_start = 0; load_abort = 0; rb_start = 0;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
        s_load_start = 0; s_load_abort = 0; s_rb_start = 0;
        bus1.in_valid = 0; bus1.in_data = '0; bus1.out_ready = 0;
        exp_reset();
        repeat (3) step();
        rst = 1'b1;
        chk_en = 1'b1;
        step();

        // reset state
        check("rst_config",    config_data,   0);
        check("rst_busy",      busy,          0);
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_done",      done,          0);

        // index load, valid held
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        feed(D, 0);
        check("pre_commit_cfg",  config_data, 0);
        check("pre_commit_done", done,        0);
        step();
        check("commit_done", done,        1);
        check("commit_cfg",  config_data, idx_cfg);
        step();
        check("done_pulse_end", done, 0);

        // index load with valid toggling, then two readbacks
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        feed(D, 1);
        repeat (2) step();
        check("toggle_cfg", config_data, idx_cfg);
        for (int pass = 0; pass < 2; pass++) begin
            readback();
            compare_rb("rb_index");
            for (int i = 0; i < D && i < got_q.size(); i++)
                check("rb_index_lit", got_q[i], i);
        end

        // partial load of all-ones, abort alongside a valid beat
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        feed(5, 2);
        load_abort   = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = {L{1'b1}};
        step();
        load_abort   = 1'b0;
        bus.in_valid = 1'b0;
        check("abort_busy",     busy,        0);
        check("abort_beat_cnt", beat_cnt,    5);
        check("abort_cfg",      config_data, idx_cfg);
        step();
        check("abort_no_done",  done,        0);
        readback();
        compare_rb("rb_abort");
        for (int i = 0; i < D && i < got_q.size(); i++)
            check("rb_abort_lit", got_q[i], (i < 11) ? i + 5 : 15);

        // simultaneous start requests, then reset mid-load
        load_start = 1'b1;
        rb_start   = 1'b1;
        step();
        load_start = 1'b0;
        rb_start   = 1'b0;
        check("both_in_ready",  bus.in_ready,  1);
        check("both_out_valid", bus.out_valid, 0);
        feed(8, 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_reset();
        check("midrst_cfg",  config_data, 0);
        check("midrst_busy", busy,        0);
        step();
        check("midrst_idle", busy, 0);

        // randomized sessions: full loads or aborted partial loads
        for (int r = 0; r < 8; r++) begin
            int k;
            k = $urandom_range(1, D);
            load_start = 1'b1;
            step();
            load_start = 1'b0;
            feed(k, 3);
            if (k < D) begin
                load_abort = 1'b1;
                step();
                load_abort = 1'b0;
            end else begin
                step();
            end
            step();
            readback();
            compare_rb("rb_random");
        end
        chk_en = 1'b0;

        // DEPTH=1, LANES=1 build
        s_load_start = 1'b1;
        step();
        s_load_start = 1'b0;
        bus1.in_valid = 1'b1;
        bus1.in_data  = 1'b1;
        step();
        bus1.in_valid = 1'b0;
        check("d1_commit_busy", s_busy,   1);
        check("d1_commit_done", s_done,   0);
        check("d1_commit_cfg",  s_config, 0);
        step();
        check("d1_done",     s_done,     1);
        check("d1_cfg",      s_config,   1);
        check("d1_beat_cnt", s_beat_cnt, 1);
        step();
        check("d1_done_end", s_done, 0);
        for (int pass = 0; pass < 2; pass++) begin
            s_rb_start = 1'b1;
            step();
            s_rb_start = 1'b0;
            check("d1_out_valid", bus1.out_valid, 1);
            check("d1_out_data",  bus1.out_data,  1);
            bus1.out_ready = 1'b1;
            step();
            bus1.out_ready = 1'b0;
            check("d1_rb_idle", bus1.out_valid, 0);
            check("d1_rb_cfg",  s_config,       1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Overall time bound.
    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
